// File: rtl/val2_shifter_pipe_if.sv
`default_nettype none
// ============================================================================
// Module   : val2_shifter_pipe_if
// Brief    : Operand-in / Val2-out handshake bundle for val2_shifter_pipe.
// Revision : 1.0 - initial release
// ============================================================================
interface val2_shifter_pipe_if #(
    parameter int DATA_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] val_rm;
    logic [DATA_W-1:0] val_rs;
    logic [11:0]       shift_operand;
    logic              immediate;
    logic              is_mem_command;
    logic              carry_in;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] val2;
    logic              carry_out;

    modport slave (
        input  in_valid, val_rm, val_rs, shift_operand, immediate,
               is_mem_command, carry_in, out_ready,
        output in_ready, out_valid, val2, carry_out
    );

    modport master (
        output in_valid, val_rm, val_rs, shift_operand, immediate,
               is_mem_command, carry_in, out_ready,
        input  in_ready, out_valid, val2, carry_out
    );
endinterface
`default_nettype wire

// File: rtl/val2_shifter_pipe.sv
`default_nettype none
// ============================================================================
// Module   : val2_shifter_pipe
// Brief    : Pipelined ARM Val2 operand generator (imm rotate, imm/reg shift,
//            mem offset). Define VAL2_CARRY_OUT_EN to build the carry-out path.
// Revision : 1.0 - initial release
// ============================================================================
module val2_shifter_pipe #(
    parameter int DATA_W      = 32,
    parameter int PIPE_STAGES = 2
) (
    input  wire logic          clk,
    input  wire logic          rst,
    input  wire logic          flush,
    val2_shifter_pipe_if.slave bus
);
    localparam int c_amt_w = $clog2(DATA_W) + 1;
    localparam logic [c_amt_w-1:0] c_width_amt = c_amt_w'(DATA_W);

    typedef enum logic [2:0] {
        OP_LSL = 3'd0,
        OP_LSR = 3'd1,
        OP_ASR = 3'd2,
        OP_ROR = 3'd3,
        OP_RRX = 3'd4
    } op_e;

    // Amounts beyond the width collapse to DATA_W+1: shifts yield 0/fill, carry 0/fill.
    function automatic logic [c_amt_w-1:0] sat_amt(input logic [7:0] a);
        logic [31:0] t;
        t = {24'd0, a};
        if (t > DATA_W) t = DATA_W + 1;
        return t[c_amt_w-1:0];
    endfunction

    // Rotation mod DATA_W; a non-zero multiple of the width becomes a full turn.
    function automatic logic [c_amt_w-1:0] ror_amt(input logic [7:0] a);
        logic [31:0] t;
        t = {24'd0, a} & (DATA_W - 1);
        if (t == 32'd0 && a != 8'd0) t = DATA_W;
        return t[c_amt_w-1:0];
    endfunction

    op_e                w_dec_op;
    logic [c_amt_w-1:0] w_dec_amt;
    logic [DATA_W-1:0]  w_dec_src;
    logic               w_dec_cin;
    logic [7:0]         w_imm_amt;
    logic [7:0]         w_reg_amt;
    logic               w_unused_rs;

    assign w_imm_amt   = {3'b000, bus.shift_operand[11:7]};
    assign w_reg_amt   = bus.val_rs[7:0];
    assign w_unused_rs = &{1'b0, bus.val_rs[DATA_W-1:8]};

    always_comb begin
        w_dec_op  = OP_LSL;
        w_dec_amt = '0;
        w_dec_src = bus.val_rm;
        w_dec_cin = bus.carry_in;
        if (bus.is_mem_command) begin
            w_dec_src = {{(DATA_W-12){bus.shift_operand[11]}}, bus.shift_operand};
        end else if (bus.immediate) begin
            w_dec_src = {{(DATA_W-8){1'b0}}, bus.shift_operand[7:0]};
            w_dec_op  = OP_ROR;
            w_dec_amt = ror_amt({3'b000, bus.shift_operand[11:8], 1'b0});
        end else if (!bus.shift_operand[4]) begin
            case (bus.shift_operand[6:5])
                2'b00: begin
                    w_dec_op  = OP_LSL;
                    w_dec_amt = sat_amt(w_imm_amt);
                end
                2'b01: begin
                    w_dec_op  = OP_LSR;
                    w_dec_amt = (w_imm_amt == 8'd0) ? c_width_amt : sat_amt(w_imm_amt);
                end
                2'b10: begin
                    w_dec_op  = OP_ASR;
                    w_dec_amt = (w_imm_amt == 8'd0) ? c_width_amt : sat_amt(w_imm_amt);
                end
                default: begin
                    w_dec_op  = (w_imm_amt == 8'd0) ? OP_RRX : OP_ROR;
                    w_dec_amt = ror_amt(w_imm_amt);
                end
            endcase
        end else if (w_reg_amt != 8'd0) begin
            case (bus.shift_operand[6:5])
                2'b00:   begin w_dec_op = OP_LSL; w_dec_amt = sat_amt(w_reg_amt); end
                2'b01:   begin w_dec_op = OP_LSR; w_dec_amt = sat_amt(w_reg_amt); end
                2'b10:   begin w_dec_op = OP_ASR; w_dec_amt = sat_amt(w_reg_amt); end
                default: begin w_dec_op = OP_ROR; w_dec_amt = ror_amt(w_reg_amt); end
            endcase
        end
    end

    op_e                w_sh_op;
    logic [c_amt_w-1:0] w_sh_amt;
    logic [DATA_W-1:0]  w_sh_src;
    logic               w_sh_cin;
    logic [DATA_W-1:0]  w_res;

    always_comb begin
        w_res = w_sh_src;
        case (w_sh_op)
            OP_LSL:  w_res = w_sh_src << w_sh_amt;
            OP_LSR:  w_res = w_sh_src >> w_sh_amt;
            OP_ASR:  w_res = $signed(w_sh_src) >>> w_sh_amt;
            OP_ROR:  w_res = (w_sh_src >> w_sh_amt) | (w_sh_src << (c_width_amt - w_sh_amt));
            OP_RRX:  w_res = {w_sh_cin, w_sh_src[DATA_W-1:1]};
            default: w_res = w_sh_src;
        endcase
    end

`ifdef VAL2_CARRY_OUT_EN
    // Carry is the last bit shifted out, i.e. the operand shifted by amount-1.
    logic [c_amt_w-1:0] w_amt_m1;
    logic [DATA_W-1:0]  w_lsl_m1;
    logic [DATA_W-1:0]  w_lsr_m1;
    logic [DATA_W-1:0]  w_asr_m1;
    logic               w_c;

    assign w_amt_m1 = w_sh_amt - c_amt_w'(1);
    assign w_lsl_m1 = w_sh_src << w_amt_m1;
    assign w_lsr_m1 = w_sh_src >> w_amt_m1;
    assign w_asr_m1 = $signed(w_sh_src) >>> w_amt_m1;

    always_comb begin
        w_c = w_sh_cin;
        case (w_sh_op)
            OP_LSL:  if (w_sh_amt != '0) w_c = w_lsl_m1[DATA_W-1];
            OP_LSR:  if (w_sh_amt != '0) w_c = w_lsr_m1[0];
            OP_ASR:  if (w_sh_amt != '0) w_c = w_asr_m1[0];
            OP_ROR:  if (w_sh_amt != '0) w_c = w_lsr_m1[0];
            OP_RRX:  w_c = w_sh_src[0];
            default: w_c = w_sh_cin;
        endcase
    end
`else
    assign bus.carry_out = 1'b0;
`endif

    generate
        if (PIPE_STAGES == 2) begin : g_two_stage
            logic               s1_vld_q, s1_vld_d, s2_vld_q, s2_vld_d;
            op_e                s1_op_q;
            logic [c_amt_w-1:0] s1_amt_q;
            logic [DATA_W-1:0]  s1_src_q;
            logic               s1_cin_q;
            logic [DATA_W-1:0]  s2_val_q;
            logic               w_adv1, w_adv2;

            assign w_adv2   = !s2_vld_q | bus.out_ready;
            assign w_adv1   = !s1_vld_q | w_adv2;
            assign s1_vld_d = flush ? 1'b0 : (w_adv1 ? bus.in_valid : s1_vld_q);
            assign s2_vld_d = flush ? 1'b0 : (w_adv2 ? s1_vld_q : s2_vld_q);

            assign w_sh_op  = s1_op_q;
            assign w_sh_amt = s1_amt_q;
            assign w_sh_src = s1_src_q;
            assign w_sh_cin = s1_cin_q;

            assign bus.in_ready  = w_adv1;
            assign bus.out_valid = s2_vld_q;
            assign bus.val2      = s2_val_q;

`ifdef VAL2_CARRY_OUT_EN
            logic s2_c_q;
            assign bus.carry_out = s2_c_q;
`endif

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    s1_vld_q <= 1'b0;
                    s2_vld_q <= 1'b0;
                    s1_op_q  <= OP_LSL;
                    s1_amt_q <= '0;
                    s1_src_q <= '0;
                    s1_cin_q <= 1'b0;
                    s2_val_q <= '0;
`ifdef VAL2_CARRY_OUT_EN
                    s2_c_q   <= 1'b0;
`endif
                end else begin
                    s1_vld_q <= s1_vld_d;
                    s2_vld_q <= s2_vld_d;
                    if (bus.in_valid && w_adv1) begin
                        s1_op_q  <= w_dec_op;
                        s1_amt_q <= w_dec_amt;
                        s1_src_q <= w_dec_src;
                        s1_cin_q <= w_dec_cin;
                    end
                    if (s1_vld_q && w_adv2) begin
                        s2_val_q <= w_res;
`ifdef VAL2_CARRY_OUT_EN
                        s2_c_q   <= w_c;
`endif
                    end
                end
            end
        end else if (PIPE_STAGES == 1) begin : g_one_stage
            logic              vld_q, vld_d;
            logic [DATA_W-1:0] val_q;
            logic              w_adv;

            assign w_adv = !vld_q | bus.out_ready;
            assign vld_d = flush ? 1'b0 : (w_adv ? bus.in_valid : vld_q);

            assign w_sh_op  = w_dec_op;
            assign w_sh_amt = w_dec_amt;
            assign w_sh_src = w_dec_src;
            assign w_sh_cin = w_dec_cin;

            assign bus.in_ready  = w_adv;
            assign bus.out_valid = vld_q;
            assign bus.val2      = val_q;

`ifdef VAL2_CARRY_OUT_EN
            logic c_q;
            assign bus.carry_out = c_q;
`endif

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    vld_q <= 1'b0;
                    val_q <= '0;
`ifdef VAL2_CARRY_OUT_EN
                    c_q   <= 1'b0;
`endif
                end else begin
                    vld_q <= vld_d;
                    if (bus.in_valid && w_adv) begin
                        val_q <= w_res;
`ifdef VAL2_CARRY_OUT_EN
                        c_q   <= w_c;
`endif
                    end
                end
            end
        end else begin : g_bad_stages
            $error("val2_shifter_pipe: PIPE_STAGES must be 1 or 2");
        end
    endgenerate
endmodule
`default_nettype wire

// File: tb/tb_val2_shifter_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_val2_shifter_pipe
// Brief    : Directed + random bench for val2_shifter_pipe against a bit-serial
//            reference model and an in-order scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_val2_shifter_pipe;
    localparam int c_w = 32;
`ifdef VAL2_CARRY_OUT_EN
    localparam bit c_cen = 1'b1;
`else
    localparam bit c_cen = 1'b0;
`endif

    typedef struct packed {
        logic [c_w-1:0] v;
        logic           c;
    } exp_t;

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic flush = 1'b0;
    always #5 clk = ~clk;

    val2_shifter_pipe_if #(.DATA_W(c_w)) bus_if ();

    val2_shifter_pipe #(.DATA_W(c_w), .PIPE_STAGES(2)) dut (
        .clk  (clk),
        .rst  (rst),
        .flush(flush),
        .bus  (bus_if)
    );

    int   n_vec = 0;
    int   n_err = 0;
    exp_t q[$];
    exp_t cur_exp;
    exp_t hold_val;
    logic hold_active = 1'b0;
    logic acc = 1'b0;

    task automatic chk(input string tag, input logic [c_w:0] obs, input logic [c_w:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic exp_t cexp(input logic [c_w-1:0] v, input logic c);
        exp_t e;
        e.v = v;
        e.c = c_cen ? c : 1'b0;
        return e;
    endfunction

    // Reference: shift one bit at a time; the carry is whatever fell off last.
    function automatic exp_t model(input logic [c_w-1:0] rm, input logic [c_w-1:0] rs,
                                   input logic [11:0] so, input logic imm,
                                   input logic mem, input logic cin);
        logic [c_w-1:0] v;
        logic           c;
        int             amt;
        logic [1:0]     ty;
        v  = rm;
        c  = cin;
        ty = so[6:5];
        if (mem) begin
            v = {{(c_w-12){so[11]}}, so};
        end else if (imm) begin
            v   = {{(c_w-8){1'b0}}, so[7:0]};
            amt = 2 * int'(so[11:8]);
            for (int k = 0; k < amt; k++) begin
                c = v[0];
                v = {v[0], v[c_w-1:1]};
            end
        end else if (!so[4] && so[11:7] == 5'd0 && ty == 2'b11) begin
            v = {cin, rm[c_w-1:1]};
            c = rm[0];
        end else begin
            if (!so[4]) begin
                amt = int'(so[11:7]);
                if (amt == 0 && (ty == 2'b01 || ty == 2'b10)) amt = c_w;
            end else begin
                amt = int'(rs[7:0]);
            end
            for (int k = 0; k < amt; k++) begin
                case (ty)
                    2'b00: begin c = v[c_w-1]; v = v << 1; end
                    2'b01: begin c = v[0]; v = v >> 1; end
                    2'b10: begin c = v[0]; v = {v[c_w-1], v[c_w-1:1]}; end
                    default: begin c = v[0]; v = {v[0], v[c_w-1:1]}; end
                endcase
            end
        end
        return cexp(v, c);
    endfunction

    // One clock: sample just after the negedge, score, then advance to next negedge.
    task automatic cyc();
        exp_t want;
        #1;
        if (hold_active) begin
            chk("hold_valid", (c_w+1)'(bus_if.out_valid), (c_w+1)'(1));
            chk("hold_val2", (c_w+1)'(bus_if.val2), (c_w+1)'(hold_val.v));
            chk("hold_carry", (c_w+1)'(bus_if.carry_out), (c_w+1)'(hold_val.c));
        end
        acc = bus_if.in_valid & bus_if.in_ready;
        if (bus_if.out_ready) begin
            if (q.size() == 0) begin
                chk("no_stale", (c_w+1)'(bus_if.out_valid), (c_w+1)'(0));
            end else if (bus_if.out_valid) begin
                want = q.pop_front();
                chk("val2", (c_w+1)'(bus_if.val2), (c_w+1)'(want.v));
                chk("carry", (c_w+1)'(bus_if.carry_out), (c_w+1)'(want.c));
            end
        end
        if (acc && !flush) q.push_back(cur_exp);
        if (flush) q.delete();
        hold_active = bus_if.out_valid & !bus_if.out_ready & !flush;
        hold_val.v  = bus_if.val2;
        hold_val.c  = bus_if.carry_out;
        @(negedge clk);
    endtask

    task automatic drive(input logic [c_w-1:0] rm, input logic [c_w-1:0] rs,
                         input logic [11:0] so, input logic imm, input logic mem,
                         input logic cin, input exp_t e);
        bus_if.val_rm         = rm;
        bus_if.val_rs         = rs;
        bus_if.shift_operand  = so;
        bus_if.immediate      = imm;
        bus_if.is_mem_command = mem;
        bus_if.carry_in       = cin;
        bus_if.in_valid       = 1'b1;
        cur_exp               = e;
    endtask

    task automatic wait_acc();
        int k;
        k = 0;
        cyc();
        while (!acc && k < 50) begin
            cyc();
            k++;
        end
        chk("accept_timeout", (c_w+1)'(acc), (c_w+1)'(1));
        bus_if.in_valid = 1'b0;
    endtask

    task automatic send(input logic [c_w-1:0] rm, input logic [c_w-1:0] rs,
                        input logic [11:0] so, input logic imm, input logic mem,
                        input logic cin, input exp_t e);
        drive(rm, rs, so, imm, mem, cin, e);
        wait_acc();
    endtask

    task automatic drain();
        int k;
        k = 0;
        bus_if.in_valid  = 1'b0;
        bus_if.out_ready = 1'b1;
        while (q.size() != 0 && k < 100) begin
            cyc();
            k++;
        end
        chk("drain_timeout", (c_w+1)'(q.size() == 0), (c_w+1)'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [c_w-1:0] rm, rs, r32;
        logic [11:0]    so;
        logic           imm, mem, cin;
        int             mode;

        bus_if.in_valid       = 1'b0;
        bus_if.out_ready      = 1'b1;
        bus_if.val_rm         = '0;
        bus_if.val_rs         = '0;
        bus_if.shift_operand  = '0;
        bus_if.immediate      = 1'b0;
        bus_if.is_mem_command = 1'b0;
        bus_if.carry_in       = 1'b0;
        cur_exp               = '0;
        hold_val              = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_out_valid", (c_w+1)'(bus_if.out_valid), (c_w+1)'(0));
        chk("rst_val2", (c_w+1)'(bus_if.val2), (c_w+1)'(0));
        chk("rst_carry", (c_w+1)'(bus_if.carry_out), (c_w+1)'(0));
        rst = 1'b0;
        #1;
        chk("rdy_after_rst", (c_w+1)'(bus_if.in_ready), (c_w+1)'(1));
        @(negedge clk);

        // Immediate rotate and two-cycle latency
        drive(32'h0, 32'h0, 12'h4FF, 1'b1, 1'b0, 1'b0, cexp(32'hFF00_0000, 1'b1));
        cyc();
        bus_if.in_valid = 1'b0;
        chk("lat_accepted", (c_w+1)'(acc), (c_w+1)'(1));
        chk("lat_cycle1", (c_w+1)'(bus_if.out_valid), (c_w+1)'(0));
        cyc();
        chk("lat_cycle2", (c_w+1)'(bus_if.out_valid), (c_w+1)'(1));
        cyc();

        // Immediate-amount shift corner cases
        send(32'h8000_0001, 32'h0, 12'h040, 1'b0, 1'b0, 1'b0, cexp(32'hFFFF_FFFF, 1'b1));
        send(32'h8000_0001, 32'h0, 12'h060, 1'b0, 1'b0, 1'b0, cexp(32'h4000_0000, 1'b1));
        // Register-amount shifts at and beyond the width
        send(32'h8000_0001, 32'd32, 12'h030, 1'b0, 1'b0, 1'b0, cexp(32'h0, 1'b1));
        send(32'h8000_0001, 32'd33, 12'h030, 1'b0, 1'b0, 1'b1, cexp(32'h0, 1'b0));
        send(32'h8000_0001, 32'd36, 12'h070, 1'b0, 1'b0, 1'b0, cexp(32'h1800_0000, 1'b0));
        // Memory offsets
        send(32'h1234_5678, 32'h0, 12'h800, 1'b0, 1'b1, 1'b1, cexp(32'hFFFF_F800, 1'b1));
        send(32'h1234_5678, 32'h0, 12'h7FF, 1'b0, 1'b1, 1'b0, cexp(32'h0000_07FF, 1'b0));
        drain();

        // Backpressure: four back-to-back inputs, consumer stalled three cycles
        bus_if.out_ready = 1'b0;
        drive(32'h0000_00F0, 32'd4, 12'h010, 1'b0, 1'b0, 1'b0,
              model(32'h0000_00F0, 32'd4, 12'h010, 1'b0, 1'b0, 1'b0));
        cyc();
        drive(32'hF000_000F, 32'd8, 12'h050, 1'b0, 1'b0, 1'b1,
              model(32'hF000_000F, 32'd8, 12'h050, 1'b0, 1'b0, 1'b1));
        cyc();
        drive(32'h0, 32'h0, 12'h1AB, 1'b1, 1'b0, 1'b0,
              model(32'h0, 32'h0, 12'h1AB, 1'b1, 1'b0, 1'b0));
        chk("bp_in_ready_low", (c_w+1)'(bus_if.in_ready), (c_w+1)'(0));
        cyc();
        bus_if.out_ready = 1'b1;
        wait_acc();
        drive(32'hDEAD_BEEF, 32'h0, 12'h3C5, 1'b0, 1'b1, 1'b1,
              model(32'hDEAD_BEEF, 32'h0, 12'h3C5, 1'b0, 1'b1, 1'b1));
        wait_acc();
        drain();

        // Flush with two entries in flight, plus an input offered that cycle
        bus_if.out_ready = 1'b0;
        drive(32'h1111_1111, 32'd1, 12'h010, 1'b0, 1'b0, 1'b0,
              model(32'h1111_1111, 32'd1, 12'h010, 1'b0, 1'b0, 1'b0));
        cyc();
        drive(32'h2222_2222, 32'd2, 12'h030, 1'b0, 1'b0, 1'b0,
              model(32'h2222_2222, 32'd2, 12'h030, 1'b0, 1'b0, 1'b0));
        cyc();
        drive(32'h3333_3333, 32'd3, 12'h050, 1'b0, 1'b0, 1'b0,
              model(32'h3333_3333, 32'd3, 12'h050, 1'b0, 1'b0, 1'b0));
        flush = 1'b1;
        cyc();
        flush           = 1'b0;
        bus_if.in_valid = 1'b0;
        chk("flush_out_valid", (c_w+1)'(bus_if.out_valid), (c_w+1)'(0));
        bus_if.out_ready = 1'b1;
        repeat (3) cyc();

        // Asynchronous reset mid-stream
        drive(32'hAAAA_5555, 32'd7, 12'h070, 1'b0, 1'b0, 1'b0,
              model(32'hAAAA_5555, 32'd7, 12'h070, 1'b0, 1'b0, 1'b0));
        cyc();
        drive(32'h5555_AAAA, 32'h0, 12'h0E3, 1'b0, 1'b0, 1'b1,
              model(32'h5555_AAAA, 32'h0, 12'h0E3, 1'b0, 1'b0, 1'b1));
        cyc();
        bus_if.in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", (c_w+1)'(bus_if.out_valid), (c_w+1)'(0));
        chk("arst_val2", (c_w+1)'(bus_if.val2), (c_w+1)'(0));
        chk("arst_carry", (c_w+1)'(bus_if.carry_out), (c_w+1)'(0));
        q.delete();
        hold_active = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) cyc();

        // Randomised traffic with random backpressure and occasional flush
        for (int i = 0; i < 300; i++) begin
            rm   = $urandom;
            rs   = $urandom;
            r32  = $urandom;
            so   = r32[11:0];
            cin  = r32[30];
            mode = $urandom_range(0, 3);
            case ($urandom_range(0, 7))
                0: rs[7:0] = 8'd0;
                1: rs[7:0] = 8'd1;
                2: rs[7:0] = 8'd31;
                3: rs[7:0] = 8'd32;
                4: rs[7:0] = 8'd33;
                5: rs[7:0] = 8'd64;
                6: rs[7:0] = 8'd255;
                default: rs[7:0] = rs[7:0];
            endcase
            mem = (mode == 0);
            imm = (mode == 1) || (mode == 0 && r32[31]);
            if (mode == 2) so[4] = 1'b0;
            if (mode == 3) begin
                so[4] = 1'b1;
                so[7] = 1'b0;
            end
            if ($urandom_range(0, 9) < 7) drive(rm, rs, so, imm, mem, cin, model(rm, rs, so, imm, mem, cin));
            else bus_if.in_valid = 1'b0;
            bus_if.out_ready = ($urandom_range(0, 9) < 7);
            flush            = ($urandom_range(0, 49) == 0);
            cyc();
        end
        flush = 1'b0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
